// File: rtl/packet_arbiter_4.sv
// Four-input wormhole packet arbiter: header arbitration (farthest-first or round-robin
// with aging), packet locking until TAIL, and a single registered output stage.
module packet_arbiter_4 #(
  parameter int FLIT_SIZE      = 128,
  parameter int HEADER_LEN     = 2,
  parameter int CMP_POS        = 119,
  parameter int CMP_LEN        = 8,
  parameter int FARTHEST_FIRST = 1,
  parameter int MAX_WAIT       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*FLIT_SIZE-1:0] in_flit,
  input  logic [3:0]             in_valid,
  output logic [3:0]             in_ready,
  output logic [FLIT_SIZE-1:0]   out_flit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             grant,
  output logic                   busy,
  output logic                   err_proto
);

  localparam logic [HEADER_LEN-1:0] TYPE_HEAD   = HEADER_LEN'(2'd0);
  localparam logic [HEADER_LEN-1:0] TYPE_BODY   = HEADER_LEN'(2'd1);
  localparam logic [HEADER_LEN-1:0] TYPE_TAIL   = HEADER_LEN'(2'd2);
  localparam logic [HEADER_LEN-1:0] TYPE_SINGLE = HEADER_LEN'(2'd3);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  function automatic logic is_header(input logic [HEADER_LEN-1:0] t);
    return (t == TYPE_HEAD) || (t == TYPE_SINGLE);
  endfunction

  state_t                state_r, state_nx;
  logic [1:0]            owner_r, owner_nx, rr_r, rr_nx;
  logic [3:0]            wait_r [4];
  logic [3:0]            wait_nx [4];
  logic [FLIT_SIZE-1:0]  out_flit_r;
  logic                  out_valid_r, err_r, err_nx;

  logic [FLIT_SIZE-1:0]  flit_s [4];
  logic [HEADER_LEN-1:0] type_s [4];
  logic [CMP_LEN-1:0]    dist_s [4];
  logic [3:0]            hdr_s, cand_s, aged_s;
  logic                  stage_free_s, win_vld_s, accept_s, acc_hdr_s;
  logic [1:0]            win_s, sel_s, scan_s, old_idx_s, far_idx_s;
  logic                  old_hit_s, far_hit_s, take_old_s, take_far_s;
  logic [CMP_LEN-1:0]    far_dist_s;
  logic [HEADER_LEN-1:0] acc_type_s;
  logic [FLIT_SIZE-1:0]  acc_flit_s;

  assign stage_free_s = !out_valid_r || out_ready;
  assign out_flit     = out_flit_r;
  assign out_valid    = out_valid_r;
  assign err_proto    = err_r;

  // Per-input field decode.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      flit_s[i] = in_flit[i*FLIT_SIZE +: FLIT_SIZE];
      type_s[i] = flit_s[i][FLIT_SIZE-1 -: HEADER_LEN];
      dist_s[i] = flit_s[i][CMP_POS -: CMP_LEN];
      hdr_s[i]  = is_header(type_s[i]);
      cand_s[i] = in_valid[i] && hdr_s[i];
      aged_s[i] = wait_r[i] >= 4'(MAX_WAIT);
    end
  end

  // Winner search in rr order: first aged candidate, else farthest (strictly larger keeps rr tie order).
  always_comb begin
    old_hit_s  = 1'b0;
    old_idx_s  = 2'd0;
    far_hit_s  = 1'b0;
    far_idx_s  = 2'd0;
    far_dist_s = '0;
    scan_s     = 2'd0;
    take_old_s = 1'b0;
    take_far_s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      scan_s     = rr_r + 2'(k);
      take_old_s = cand_s[scan_s] && aged_s[scan_s] && !old_hit_s;
      take_far_s = cand_s[scan_s] &&
                   (!far_hit_s || ((FARTHEST_FIRST != 0) && (dist_s[scan_s] > far_dist_s)));
      old_idx_s  = take_old_s ? scan_s : old_idx_s;
      old_hit_s  = old_hit_s || take_old_s;
      far_idx_s  = take_far_s ? scan_s : far_idx_s;
      far_dist_s = take_far_s ? dist_s[scan_s] : far_dist_s;
      far_hit_s  = far_hit_s || take_far_s;
    end
    win_vld_s = |cand_s;
    win_s     = old_hit_s ? old_idx_s : far_idx_s;
  end

  // FSM outputs: ready steering, grant and busy.
  always_comb begin
    in_ready = 4'b0000;
    grant    = 4'b0000;
    busy     = 1'b0;
    sel_s    = win_s;
    case (state_r)
      ST_IDLE: begin
        sel_s = win_s;
        if (!rst && stage_free_s && win_vld_s) begin
          in_ready = 4'b0001 << win_s;
        end else begin
          in_ready = 4'b0000;
        end
      end
      ST_LOCKED: begin
        sel_s = owner_r;
        grant = 4'b0001 << owner_r;
        busy  = 1'b1;
        if (!rst && stage_free_s) begin
          in_ready = 4'b0001 << owner_r;
        end else begin
          in_ready = 4'b0000;
        end
      end
      default: begin
        sel_s    = 2'd0;
        in_ready = 4'b0000;
      end
    endcase
  end

  assign accept_s   = |(in_valid & in_ready);
  assign acc_flit_s = flit_s[sel_s];
  assign acc_type_s = type_s[sel_s];
  assign acc_hdr_s  = hdr_s[sel_s];

  // FSM next state, owner, round-robin pointer and sticky error.
  always_comb begin
    state_nx = state_r;
    owner_nx = owner_r;
    rr_nx    = rr_r;
    err_nx   = err_r;
    case (state_r)
      ST_IDLE: begin
        if ((in_valid & ~hdr_s) != 4'b0000) begin
          err_nx = 1'b1;
        end else begin
          err_nx = err_r;
        end
        if (accept_s && (acc_type_s == TYPE_HEAD)) begin
          state_nx = ST_LOCKED;
          owner_nx = sel_s;
        end else if (accept_s) begin
          rr_nx = sel_s + 2'd1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (accept_s && (acc_type_s == TYPE_TAIL)) begin
          state_nx = ST_IDLE;
          rr_nx    = owner_r + 2'd1;
        end else if (accept_s && acc_hdr_s) begin
          err_nx = 1'b1;
        end else begin
          state_nx = ST_LOCKED;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Aging: count header arbitrations lost while presenting a header, clear on own win.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if ((state_r == ST_IDLE) && accept_s && (sel_s == 2'(i))) begin
        wait_nx[i] = 4'd0;
      end else if ((state_r == ST_IDLE) && accept_s && cand_s[i] && (wait_r[i] != 4'd15)) begin
        wait_nx[i] = wait_r[i] + 4'd1;
      end else begin
        wait_nx[i] = wait_r[i];
      end
    end
  end

  // FSM state register with owner, pointer, aging counters and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      owner_r <= 2'd0;
      rr_r    <= 2'd0;
      err_r   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        wait_r[i] <= 4'd0;
      end
    end else begin
      state_r <= state_nx;
      owner_r <= owner_nx;
      rr_r    <= rr_nx;
      err_r   <= err_nx;
      for (int i = 0; i < 4; i++) begin
        wait_r[i] <= wait_nx[i];
      end
    end
  end

  // Output stage: refill on accept (even while draining), otherwise empty on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_flit_r  <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_flit_r  <= acc_flit_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_flit_r  <= out_flit_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_flit_r  <= out_flit_r;
    end
  end

endmodule
